// File: rtl/id_ex_hazard_reg_pkg.sv
// Shared definitions for the decode/execute boundary: the control bundle produced by
// the control unit, its bubble value, and the opcode encodings both sides agree on.
package id_ex_hazard_reg_pkg;

    localparam int REG_W   = 5;
    localparam int FUNCT_W = 4;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: a load in EX whose destination is read by the instruction in ID.
// rs2 is compared for every opcode, so I-type instructions may stall needlessly; that is accepted.
module load_use_detect
    import id_ex_hazard_reg_pkg::*;
(
    input  logic             mem_read_ex,
    input  logic             valid_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic [REG_W-1:0] rs1_in,
    input  logic [REG_W-1:0] rs2_in,
    input  logic             flush,
    output logic             stall
);

    logic src_match;

    assign src_match = (rd_ex == rs1_in) || (rd_ex == rs2_in);

    // A flush kills the ID instruction anyway, so stalling for it would only waste a cycle.
    assign stall = mem_read_ex && valid_ex && (rd_ex != '0) && src_match && !flush;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall generation, branch flush and saturating
// stall/flush performance counters.
module id_ex_hazard_reg
    import id_ex_hazard_reg_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          ALUOp_in,
    input  logic                Branch_in,
    input  logic                MemRead_in,
    input  logic                MemtoReg_in,
    input  logic                MemWrite_in,
    input  logic                ALUSrc_in,
    input  logic                RegWrite_in,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic [DATA_W-1:0]   rs1_data_in,
    input  logic [DATA_W-1:0]   rs2_data_in,
    input  logic [DATA_W-1:0]   imm_in,
    input  logic [REG_W-1:0]    rs1_in,
    input  logic [REG_W-1:0]    rs2_in,
    input  logic [REG_W-1:0]    rd_in,
    input  logic [FUNCT_W-1:0]  funct_in,
    input  logic                flush,
    output logic                stall,
    output logic                pc_write,
    output logic                if_id_write,
    output logic [1:0]          ALUOp_ex,
    output logic                Branch_ex,
    output logic                MemRead_ex,
    output logic                MemtoReg_ex,
    output logic                MemWrite_ex,
    output logic                ALUSrc_ex,
    output logic                RegWrite_ex,
    output logic [DATA_W-1:0]   pc_ex,
    output logic [DATA_W-1:0]   rs1_data_ex,
    output logic [DATA_W-1:0]   rs2_data_ex,
    output logic [DATA_W-1:0]   imm_ex,
    output logic [REG_W-1:0]    rs1_ex,
    output logic [REG_W-1:0]    rs2_ex,
    output logic [REG_W-1:0]    rd_ex,
    output logic [FUNCT_W-1:0]  funct_ex,
    output logic                valid_ex,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t ctrl_in;
    ctrl_t ctrl_ex;
    logic  hazard;
    logic  bubble;

    assign ctrl_in = '{
        alu_op:     ALUOp_in,
        branch:     Branch_in,
        mem_read:   MemRead_in,
        mem_to_reg: MemtoReg_in,
        mem_write:  MemWrite_in,
        alu_src:    ALUSrc_in,
        reg_write:  RegWrite_in
    };

    load_use_detect u_detect (
        .mem_read_ex (ctrl_ex.mem_read),
        .valid_ex    (valid_ex),
        .rd_ex       (rd_ex),
        .rs1_in      (rs1_in),
        .rs2_in      (rs2_in),
        .flush       (flush),
        .stall       (hazard)
    );

    assign stall       = hazard;
    assign pc_write    = ~hazard;
    assign if_id_write = ~hazard;
    assign bubble      = flush | hazard;

    // NOTE: the data fields are reset and bubbled to zero as well, so EX never sees stale operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_ex     <= CTRL_BUBBLE;
            valid_ex    <= 1'b0;
            pc_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            rs1_ex      <= '0;
            rs2_ex      <= '0;
            rd_ex       <= '0;
            funct_ex    <= '0;
        end else if (bubble) begin
            // NOTE: non-blocking assignments, so every field samples its pre-edge value.
            ctrl_ex     <= CTRL_BUBBLE;
            valid_ex    <= 1'b0;
            pc_ex       <= '0;
            rs1_data_ex <= '0;
            rs2_data_ex <= '0;
            imm_ex      <= '0;
            rs1_ex      <= '0;
            rs2_ex      <= '0;
            rd_ex       <= '0;
            funct_ex    <= '0;
        end else begin
            ctrl_ex     <= ctrl_in;
            valid_ex    <= 1'b1;
            pc_ex       <= pc_in;
            rs1_data_ex <= rs1_data_in;
            rs2_data_ex <= rs2_data_in;
            imm_ex      <= imm_in;
            rs1_ex      <= rs1_in;
            rs2_ex      <= rs2_in;
            rd_ex       <= rd_in;
            funct_ex    <= funct_in;
        end
    end

    // hazard is already gated by flush, so a flushed would-be stall counts only as a flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign ALUOp_ex    = ctrl_ex.alu_op;
    assign Branch_ex   = ctrl_ex.branch;
    assign MemRead_ex  = ctrl_ex.mem_read;
    assign MemtoReg_ex = ctrl_ex.mem_to_reg;
    assign MemWrite_ex = ctrl_ex.mem_write;
    assign ALUSrc_ex   = ctrl_ex.alu_src;
    assign RegWrite_ex = ctrl_ex.reg_write;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: a driver feeds ID instructions and a behavioural
// model queues the expected stall and EX contents; a monitor pops and compares every cycle.
module tb_id_ex_hazard_reg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        ALUOp_in;
    logic              Branch_in, MemRead_in, MemtoReg_in, MemWrite_in, ALUSrc_in, RegWrite_in;
    logic [DATA_W-1:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
    logic [4:0]        rs1_in, rs2_in, rd_in;
    logic [3:0]        funct_in;
    logic              flush;
    logic              stall, pc_write, if_id_write;
    logic [1:0]        ALUOp_ex;
    logic              Branch_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex;
    logic [DATA_W-1:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
    logic [4:0]        rs1_ex, rs2_ex, rd_ex;
    logic [3:0]        funct_ex;
    logic              valid_ex;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    id_ex_hazard_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .ALUOp_in(ALUOp_in), .Branch_in(Branch_in), .MemRead_in(MemRead_in),
        .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in), .ALUSrc_in(ALUSrc_in),
        .RegWrite_in(RegWrite_in), .pc_in(pc_in), .rs1_data_in(rs1_data_in),
        .rs2_data_in(rs2_data_in), .imm_in(imm_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .rd_in(rd_in), .funct_in(funct_in), .flush(flush),
        .stall(stall), .pc_write(pc_write), .if_id_write(if_id_write),
        .ALUOp_ex(ALUOp_ex), .Branch_ex(Branch_ex), .MemRead_ex(MemRead_ex),
        .MemtoReg_ex(MemtoReg_ex), .MemWrite_ex(MemWrite_ex), .ALUSrc_ex(ALUSrc_ex),
        .RegWrite_ex(RegWrite_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
        .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .funct_ex(funct_ex), .valid_ex(valid_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [1:0]  aluop;
        bit        branch, memread, memtoreg, memwrite, alusrc, regwrite;
        bit [63:0] pc, rs1d, rs2d, imm;
        bit [4:0]  rs1, rs2, rd;
        bit [3:0]  funct;
    } instr_t;

    typedef struct {
        bit     stall;
        bit     valid;
        instr_t ex;
        int     scnt;
        int     fcnt;
    } exp_t;

    exp_t   q[$];
    instr_t nop_i;
    bit     m_valid;
    instr_t m_ex;
    int     m_scnt, m_fcnt;
    int     passed = 0;
    int     total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic instr_t mk_load(input bit [4:0] rd, input bit [4:0] rs1);
        instr_t x = nop_i;
        x.memread = 1; x.memtoreg = 1; x.regwrite = 1; x.alusrc = 1;
        x.rd = rd; x.rs1 = rs1; x.rs2 = 5'd0; x.imm = 64'd8; x.funct = 4'b0011;
        x.pc = {32'd0, $urandom}; x.rs1d = {$urandom, $urandom};
        return x;
    endfunction

    function automatic instr_t mk_alu(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        instr_t x = nop_i;
        x.aluop = 2'b10; x.regwrite = 1;
        x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        x.pc = {32'd0, $urandom}; x.rs1d = {$urandom, $urandom}; x.rs2d = {$urandom, $urandom};
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        x.aluop = 2'($urandom); x.branch = 1'($urandom); x.memread = 1'($urandom);
        x.memtoreg = 1'($urandom); x.memwrite = 1'($urandom); x.alusrc = 1'($urandom);
        x.regwrite = 1'($urandom);
        x.pc = {$urandom, $urandom}; x.rs1d = {$urandom, $urandom};
        x.rs2d = {$urandom, $urandom}; x.imm = {$urandom, $urandom};
        x.rs1 = 5'($urandom_range(0, 7)); x.rs2 = 5'($urandom_range(0, 7));
        x.rd = 5'($urandom_range(0, 7)); x.funct = 4'($urandom);
        return x;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ex = nop_i; m_scnt = 0; m_fcnt = 0;
    endtask

    // Drive one ID instruction for a cycle and queue what EX must look like afterwards.
    task automatic apply(input instr_t x, input bit fl);
        exp_t e;
        @(negedge clk);
        ALUOp_in = x.aluop; Branch_in = x.branch; MemRead_in = x.memread;
        MemtoReg_in = x.memtoreg; MemWrite_in = x.memwrite; ALUSrc_in = x.alusrc;
        RegWrite_in = x.regwrite; pc_in = x.pc; rs1_data_in = x.rs1d; rs2_data_in = x.rs2d;
        imm_in = x.imm; rs1_in = x.rs1; rs2_in = x.rs2; rd_in = x.rd; funct_in = x.funct;
        flush = fl;
        #1;
        e.stall = !fl && m_valid && m_ex.memread && (m_ex.rd != 0)
                  && (m_ex.rd == x.rs1 || m_ex.rd == x.rs2);
        if (fl || e.stall) begin
            m_valid = 0; m_ex = nop_i;
        end else begin
            m_valid = 1; m_ex = x;
        end
        if (e.stall) m_scnt = (m_scnt + 1 > CMAX) ? CMAX : m_scnt + 1;
        if (fl)      m_fcnt = (m_fcnt + 1 > CMAX) ? CMAX : m_fcnt + 1;
        e.valid = m_valid; e.ex = m_ex; e.scnt = m_scnt; e.fcnt = m_fcnt;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q[0];
                check("stall", stall, e.stall);
                check("pc_write", pc_write, !e.stall);
                check("if_id_write", if_id_write, !e.stall);
                @(posedge clk);
                #1;
                check("valid_ex", valid_ex, e.valid);
                check("ALUOp_ex", ALUOp_ex, e.ex.aluop);
                check("ctrl_ex", {Branch_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex},
                      {e.ex.branch, e.ex.memread, e.ex.memtoreg, e.ex.memwrite, e.ex.alusrc, e.ex.regwrite});
                check("pc_ex", pc_ex, e.ex.pc);
                check("rs1_data_ex", rs1_data_ex, e.ex.rs1d);
                check("rs2_data_ex", rs2_data_ex, e.ex.rs2d);
                check("imm_ex", imm_ex, e.ex.imm);
                check("regs_ex", {rs1_ex, rs2_ex, rd_ex, funct_ex},
                      {e.ex.rs1, e.ex.rs2, e.ex.rd, e.ex.funct});
                check("stall_cnt", stall_cnt, 64'(e.scnt));
                check("flush_cnt", flush_cnt, 64'(e.fcnt));
                void'(q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid_ex"}, valid_ex, 0);
        check({tag, "_ctrl_ex"}, {ALUOp_ex, Branch_ex, MemRead_ex, MemtoReg_ex, MemWrite_ex, ALUSrc_ex, RegWrite_ex}, 0);
        check({tag, "_data_ex"}, pc_ex | rs1_data_ex | rs2_data_ex | imm_ex, 0);
        check({tag, "_regs_ex"}, {rs1_ex, rs2_ex, rd_ex, funct_ex}, 0);
        check({tag, "_cnts"}, {stall_cnt, flush_cnt}, 0);
        check({tag, "_stall"}, stall, 0);
    endtask

    instr_t addi, use_i;

    initial begin
        reset_n = 0; flush = 0;
        ALUOp_in = 0; Branch_in = 0; MemRead_in = 0; MemtoReg_in = 0; MemWrite_in = 0;
        ALUSrc_in = 0; RegWrite_in = 0; pc_in = 0; rs1_data_in = 0; rs2_data_in = 0;
        imm_in = 0; rs1_in = 0; rs2_in = 0; rd_in = 0; funct_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        #2 reset_n = 1;

        // Pass-through of an addi.
        addi = nop_i;
        addi.regwrite = 1; addi.alusrc = 1; addi.imm = 64'd5; addi.rd = 5'd3; addi.rs1 = 5'd1;
        addi.pc = 64'h100; addi.rs1d = 64'h1234;
        apply(addi, 0);

        // Load-use: one stall, then the consumer passes.
        use_i = mk_alu(5'd7, 5'd5, 5'd9);
        apply(mk_load(5'd5, 5'd2), 0);
        apply(use_i, 0);
        apply(use_i, 0);

        // No hazard: load to x0, and a load whose rd is not read.
        apply(mk_load(5'd0, 5'd1), 0);
        apply(mk_alu(5'd4, 5'd0, 5'd0), 0);
        apply(mk_load(5'd5, 5'd1), 0);
        apply(mk_alu(5'd4, 5'd6, 5'd7), 0);

        // Back-to-back loads: ld x5 then ld x6,0(x5) stalls once.
        apply(mk_load(5'd5, 5'd1), 0);
        apply(mk_load(5'd6, 5'd5), 0);
        apply(mk_load(5'd6, 5'd5), 0);
        apply(mk_alu(5'd8, 5'd6, 5'd0), 0);
        apply(mk_alu(5'd8, 5'd6, 5'd0), 0);

        // Flush with a would-be hazard: only the flush counts.
        apply(mk_load(5'd5, 5'd1), 0);
        apply(use_i, 1);
        apply(use_i, 0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) apply(rand_instr(), ($urandom_range(0, 7) == 0));

        // Async reset in the middle of the high phase clears everything with no edge.
        apply(addi, 0);
        @(posedge clk);
        #3 reset_n = 0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #3 reset_n = 1;
        #1 check_all_zero("rst_release");

        // Reset while stalling: stall drops immediately.
        apply(mk_load(5'd5, 5'd2), 0);
        @(negedge clk);
        rs1_in = 5'd5; rs2_in = 5'd0; flush = 0;
        #2 check("pre_rst_stall", stall, 1);
        check("pre_rst_pc_write", pc_write, 0);
        #1 reset_n = 0;
        #1 check("rst_stall", stall, 0);
        check_all_zero("rst_mid_stall");
        model_reset();
        @(posedge clk);
        #3 reset_n = 1;

        // Counter saturation (CNT_W is small here so the ceiling is reachable).
        for (int i = 0; i < CMAX + 2; i++) begin
            apply(mk_load(5'd5, 5'd1), 0);
            apply(use_i, 0);
            apply(use_i, 0);
        end
        for (int i = 0; i < CMAX + 2; i++) apply(rand_instr(), 1);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #3 check("scoreboard_drained", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
